// File: rtl/collision_wall_array.sv
// collision_wall_array: per-frame maze/screen-edge wall flags for N_OBJ objects on the pixel clock.
// Define COLLISION_CORNER_EN to let a maze hit raise a vertical and a horizontal flag together.
module collision_wall_array #(
  parameter int N_OBJ    = 2,
  parameter int COORD_W  = 10,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic                       pixel_clk,
  input  logic                       Reset,
  input  logic [COORD_W-1:0]         DrawX,
  input  logic [COORD_W-1:0]         DrawY,
  input  logic [N_OBJ*COORD_W-1:0]   objectX,
  input  logic [N_OBJ*COORD_W-1:0]   objectY,
  input  logic [N_OBJ*COORD_W-1:0]   objectS,
  input  logic [N_OBJ*COORD_W-1:0]   X_Motion,
  input  logic [N_OBJ*COORD_W-1:0]   Y_Motion,
  input  logic [N_OBJ-1:0]           obj_en,
  input  logic                       currentMazePrime,
  input  logic                       MazeUpPrime,
  input  logic                       MazeDownPrime,
  input  logic                       MazeLeftPrime,
  input  logic                       MazeRightPrime,
  output logic [N_OBJ-1:0]           isWallTop,
  output logic [N_OBJ-1:0]           isWallBottom,
  output logic [N_OBJ-1:0]           isWallLeft,
  output logic [N_OBJ-1:0]           isWallRight,
  output logic                       hit_valid
);

  localparam int CW = COORD_W + 1;

  typedef enum logic [1:0] {WAIT_SOF, SCAN, COMMIT} state_t;

  state_t state_q, state_d;
  logic [N_OBJ-1:0] accHit_q, accHit_d, accV_q, accV_d, accH_q, accH_d;
  logic [N_OBJ-1:0] top_q, top_d, bottom_q, bottom_d, left_q, left_d, right_q, right_d;
  logic hitValid_q, hitValid_d;
  logic [N_OBJ-1:0] pixHit, cTop, cBottom, cLeft, cRight;
  logic sof, eof, vertPix, horzPix;
  logic unusedMotionBits;

  assign sof     = (DrawX == '0) && (DrawY == '0);
  assign eof     = (DrawX == COORD_W'(SCREEN_W - 1)) && (DrawY == COORD_W'(SCREEN_H - 1));
  assign vertPix = MazeUpPrime | MazeDownPrime;
  assign horzPix = MazeLeftPrime | MazeRightPrime;
  assign unusedMotionBits = ^{X_Motion, Y_Motion};

  for (genvar i = 0; i < N_OBJ; i++) begin : gObj
    logic [COORD_W-1:0] x, y, s;
    logic signed [CW-1:0] xLo, yLo;
    logic [CW-1:0] xHi, yHi;
    logic inBox, xNeg, yNeg;
    logic [3:0] flags;

    assign x    = objectX[i*COORD_W +: COORD_W];
    assign y    = objectY[i*COORD_W +: COORD_W];
    assign s    = objectS[i*COORD_W +: COORD_W];
    assign xNeg = X_Motion[i*COORD_W + COORD_W - 1];
    assign yNeg = Y_Motion[i*COORD_W + COORD_W - 1];

    // Extra bit keeps a box hanging off the left/top edge from wrapping around.
    assign xLo = $signed({1'b0, x}) - $signed({1'b0, s});
    assign yLo = $signed({1'b0, y}) - $signed({1'b0, s});
    assign xHi = {1'b0, x} + {1'b0, s};
    assign yHi = {1'b0, y} + {1'b0, s};

    assign inBox = ($signed({1'b0, DrawX}) >= xLo) && ({1'b0, DrawX} <= xHi) &&
                   ($signed({1'b0, DrawY}) >= yLo) && ({1'b0, DrawY} <= yHi);
    assign pixHit[i] = inBox && obj_en[i] && currentMazePrime;

    // Flags as {top, bottom, left, right}; screen edges beat maze hits.
    always_comb begin
      flags = 4'b0000;
      if (obj_en[i]) begin
        if (yHi >= CW'(SCREEN_H - 1))      flags = 4'b0100;
        else if (y <= s)                   flags = 4'b1000;
        else if (x <= s)                   flags = 4'b0010;
        else if (xHi >= CW'(SCREEN_W - 1)) flags = 4'b0001;
        else if (accHit_q[i]) begin
`ifdef COLLISION_CORNER_EN
          if (accV_q[i]) flags[3:2] = yNeg ? 2'b10 : 2'b01;
          if (accH_q[i]) flags[1:0] = xNeg ? 2'b10 : 2'b01;
`else
          if (accV_q[i])      flags = yNeg ? 4'b1000 : 4'b0100;
          else if (accH_q[i]) flags = xNeg ? 4'b0010 : 4'b0001;
`endif
        end
      end
    end

    assign cTop[i]    = flags[3];
    assign cBottom[i] = flags[2];
    assign cLeft[i]   = flags[1];
    assign cRight[i]  = flags[0];
  end

  // SOF reloads the accumulators in any state, so a commit still sees the previous frame.
  always_comb begin
    state_d    = state_q;
    accHit_d   = accHit_q;
    accV_d     = accV_q;
    accH_d     = accH_q;
    top_d      = top_q;
    bottom_d   = bottom_q;
    left_d     = left_q;
    right_d    = right_q;
    hitValid_d = 1'b0;

    case (state_q)
      WAIT_SOF: if (sof) state_d = SCAN;
      SCAN:     if (eof) state_d = COMMIT;
      COMMIT:   state_d = SCAN;
      default:  state_d = WAIT_SOF;
    endcase

    if (sof) begin
      accHit_d = pixHit;
      accV_d   = pixHit & {N_OBJ{vertPix}};
      accH_d   = pixHit & {N_OBJ{horzPix}};
    end else if (state_q == SCAN) begin
      accHit_d = accHit_q | pixHit;
      accV_d   = accV_q | (pixHit & {N_OBJ{vertPix}});
      accH_d   = accH_q | (pixHit & {N_OBJ{horzPix}});
    end

    if (state_q == COMMIT) begin
      top_d      = cTop;
      bottom_d   = cBottom;
      left_d     = cLeft;
      right_d    = cRight;
      hitValid_d = 1'b1;
    end
  end

  always_ff @(posedge pixel_clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= WAIT_SOF;
      accHit_q   <= '0;
      accV_q     <= '0;
      accH_q     <= '0;
      top_q      <= '0;
      bottom_q   <= '0;
      left_q     <= '0;
      right_q    <= '0;
      hitValid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      accHit_q   <= accHit_d;
      accV_q     <= accV_d;
      accH_q     <= accH_d;
      top_q      <= top_d;
      bottom_q   <= bottom_d;
      left_q     <= left_d;
      right_q    <= right_d;
      hitValid_q <= hitValid_d;
    end
  end

  assign isWallTop    = top_q;
  assign isWallBottom = bottom_q;
  assign isWallLeft   = left_q;
  assign isWallRight  = right_q;
  assign hit_valid    = hitValid_q;

endmodule

// File: tb/tb_collision_wall_array.sv
// Directed bench for collision_wall_array: table of single-wall-pixel frames plus hand-written
// sequences for reset, sticky accumulation, flag hold and SOF landing in the commit cycle.
module tb_collision_wall_array;

  localparam int N  = 2;
  localparam int CW = 10;

  typedef struct {
    string      name;
    int         x0, y0, s0, xm0, ym0;
    int         x1, y1, s1, xm1, ym1;
    logic [1:0] en;
    logic       wallOn;
    int         wx, wy;
    logic       c, u, d, l, r;
    logic [1:0] eT, eB, eL, eR;
  } vec_t;

  logic            pixel_clk = 1'b0;
  logic            Reset;
  logic [CW-1:0]   DrawX, DrawY;
  logic [N*CW-1:0] objectX, objectY, objectS, X_Motion, Y_Motion;
  logic [N-1:0]    obj_en;
  logic            cur, up, dn, lf, rt;
  logic [N-1:0]    isWallTop, isWallBottom, isWallLeft, isWallRight;
  logic            hit_valid;

  int checksTotal  = 0;
  int checksPassed = 0;
  int pulseCount   = 0;
  int pulseStart;
  vec_t vecs[12];

  collision_wall_array #(.N_OBJ(N), .COORD_W(CW), .SCREEN_W(640), .SCREEN_H(480)) dut (
    .pixel_clk(pixel_clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
    .objectX(objectX), .objectY(objectY), .objectS(objectS),
    .X_Motion(X_Motion), .Y_Motion(Y_Motion), .obj_en(obj_en),
    .currentMazePrime(cur), .MazeUpPrime(up), .MazeDownPrime(dn),
    .MazeLeftPrime(lf), .MazeRightPrime(rt),
    .isWallTop(isWallTop), .isWallBottom(isWallBottom),
    .isWallLeft(isWallLeft), .isWallRight(isWallRight), .hit_valid(hit_valid)
  );

  always #5 pixel_clk = ~pixel_clk;

  always @(negedge pixel_clk) if (hit_valid) pulseCount++;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checksTotal++;
    if (actual === expected) checksPassed++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
  endtask

  task automatic checkFlags(input string name, input logic [1:0] t, b, l, r);
    checkOutput({name, " top"},    32'(isWallTop),    32'(t));
    checkOutput({name, " bottom"}, 32'(isWallBottom), 32'(b));
    checkOutput({name, " left"},   32'(isWallLeft),   32'(l));
    checkOutput({name, " right"},  32'(isWallRight),  32'(r));
  endtask

  task automatic drive(input int x, y, input logic c, u, d, l, r);
    DrawX = CW'(x);
    DrawY = CW'(y);
    cur = c; up = u; dn = d; lf = l; rt = r;
  endtask

  task automatic applyStimulus(input int x, y, input logic c, u, d, l, r);
    @(negedge pixel_clk); #1;
    drive(x, y, c, u, d, l, r);
  endtask

  task automatic idle();
    applyStimulus(5, 5, 0, 0, 0, 0, 0);
  endtask

  task automatic setObj(input int i, x, y, s, xm, ym);
    objectX[i*CW +: CW]  = CW'(x);
    objectY[i*CW +: CW]  = CW'(y);
    objectS[i*CW +: CW]  = CW'(s);
    X_Motion[i*CW +: CW] = CW'(xm);
    Y_Motion[i*CW +: CW] = CW'(ym);
  endtask

  // EOF pixel, then the COMMIT cycle (optionally presenting SOF), then the pulse and its fall.
  task automatic endFrame(input string name, input logic sofInCommit, input logic [1:0] t, b, l, r);
    applyStimulus(639, 479, 0, 0, 0, 0, 0);
    @(negedge pixel_clk); #1;
    checkOutput({name, " hit_valid early"}, 32'(hit_valid), 32'd0);
    if (sofInCommit) drive(0, 0, 0, 0, 0, 0, 0);
    else drive(5, 5, 0, 0, 0, 0, 0);
    @(negedge pixel_clk); #1;
    checkOutput({name, " hit_valid pulse"}, 32'(hit_valid), 32'd1);
    checkFlags(name, t, b, l, r);
    drive(5, 5, 0, 0, 0, 0, 0);
    @(negedge pixel_clk); #1;
    checkOutput({name, " hit_valid fall"}, 32'(hit_valid), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{"mazeTop",        100,100,4,-1,-1, 300,300,4,0,0, 2'b01, 1, 100,97,  1,1,0,0,0, 2'b01,2'b00,2'b00,2'b00};
    vecs[1]  = '{"edgeUnderflow",  2,100,4,0,0,     3,200,4,0,0,   2'b10, 0, 5,5,     0,0,0,0,0, 2'b00,2'b00,2'b10,2'b00};
    vecs[2]  = '{"edgePriority",   200,476,4,0,-1,  400,300,4,0,0, 2'b01, 1, 200,478, 1,1,0,0,0, 2'b00,2'b01,2'b00,2'b00};
    vecs[3]  = '{"mazeRight",      200,200,5,3,0,   400,300,4,0,0, 2'b11, 1, 205,200, 1,0,0,0,1, 2'b00,2'b00,2'b00,2'b01};
    vecs[4]  = '{"mazeLeft",       50,50,3,-2,1,    320,240,2,0,0, 2'b11, 1, 48,52,   1,0,0,1,0, 2'b00,2'b00,2'b01,2'b00};
    vecs[5]  = '{"outsideBox",     100,100,4,-1,-1, 300,300,4,0,0, 2'b01, 1, 105,100, 1,1,0,0,0, 2'b00,2'b00,2'b00,2'b00};
    vecs[6]  = '{"zeroMotionDown", 100,100,4,0,0,   300,300,4,0,0, 2'b01, 1, 104,104, 1,1,0,0,0, 2'b00,2'b01,2'b00,2'b00};
    vecs[7]  = '{"noCurrent",      100,100,4,-1,-1, 300,300,4,0,0, 2'b01, 1, 100,100, 0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00};
    vecs[8]  = '{"overlap",        100,100,4,0,-1,  102,102,4,0,1, 2'b11, 1, 101,101, 1,0,1,0,0, 2'b01,2'b10,2'b00,2'b00};
    vecs[9]  = '{"hitNoDir",       100,100,4,0,-1,  102,102,4,0,1, 2'b11, 1, 101,101, 1,0,0,0,0, 2'b00,2'b00,2'b00,2'b00};
    vecs[10] = '{"edgeTopRight",   300,2,3,0,0,     636,200,3,0,0, 2'b11, 0, 5,5,     0,0,0,0,0, 2'b01,2'b00,2'b00,2'b10};
`ifdef COLLISION_CORNER_EN
    vecs[11] = '{"corner",         100,100,4,-1,-1, 300,300,4,0,0, 2'b01, 1, 100,97,  1,1,0,1,0, 2'b01,2'b00,2'b01,2'b00};
`else
    vecs[11] = '{"corner",         100,100,4,-1,-1, 300,300,4,0,0, 2'b01, 1, 100,97,  1,1,0,1,0, 2'b01,2'b00,2'b00,2'b00};
`endif

    // Power-on reset with an object sitting on the left edge
    Reset = 1'b1;
    drive(5, 5, 0, 0, 0, 0, 0);
    setObj(0, 2, 100, 4, 0, 0);
    setObj(1, 300, 300, 4, 0, 0);
    obj_en = 2'b01;
    repeat (2) @(negedge pixel_clk);
    #1;
    checkFlags("reset", 2'b00, 2'b00, 2'b00, 2'b00);
    checkOutput("reset hit_valid", 32'(hit_valid), 32'd0);
    Reset = 1'b0;

    // EOF before any SOF must be ignored
    pulseStart = pulseCount;
    applyStimulus(639, 479, 0, 0, 0, 0, 0);
    repeat (3) idle();
    @(negedge pixel_clk); #1;
    checkOutput("eofInWaitSof pulses", 32'(pulseCount - pulseStart), 32'd0);
    checkFlags("eofInWaitSof", 2'b00, 2'b00, 2'b00, 2'b00);

    for (int v = 0; v < 12; v++) begin
      setObj(0, vecs[v].x0, vecs[v].y0, vecs[v].s0, vecs[v].xm0, vecs[v].ym0);
      setObj(1, vecs[v].x1, vecs[v].y1, vecs[v].s1, vecs[v].xm1, vecs[v].ym1);
      obj_en = vecs[v].en;
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      if (vecs[v].wallOn)
        applyStimulus(vecs[v].wx, vecs[v].wy, vecs[v].c, vecs[v].u, vecs[v].d, vecs[v].l, vecs[v].r);
      idle();
      endFrame(vecs[v].name, 1'b0, vecs[v].eT, vecs[v].eB, vecs[v].eL, vecs[v].eR);
    end

    // Sticky OR: a left wall then an up wall, motion down/right
    setObj(0, 100, 100, 4, 1, 2);
    obj_en = 2'b01;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(97, 100, 1, 0, 0, 1, 0);
    idle();
    applyStimulus(103, 100, 1, 1, 0, 0, 0);
`ifdef COLLISION_CORNER_EN
    endFrame("sticky", 1'b0, 2'b00, 2'b01, 2'b00, 2'b01);
`else
    endFrame("sticky", 1'b0, 2'b00, 2'b01, 2'b00, 2'b00);
`endif

    // Hit-free frame: flags hold until its own commit, one pulse
    pulseStart = pulseCount;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    idle();
    idle();
    @(negedge pixel_clk); #1;
    checkOutput("hold mid-frame bottom", 32'(isWallBottom), 32'd1);
    endFrame("holdClear", 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
    checkOutput("hold pulses", 32'(pulseCount - pulseStart), 32'd1);

    // SOF in the COMMIT cycle: commit uses old hits, accumulators restart empty
    setObj(0, 100, 100, 4, -1, -1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(100, 97, 1, 1, 0, 0, 0);
    endFrame("sofInCommit", 1'b1, 2'b01, 2'b00, 2'b00, 2'b00);
    endFrame("afterSofInCommit", 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);

    // Reset mid-SCAN with live flags, then two EOFs without SOF
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(100, 97, 1, 1, 0, 0, 0);
    endFrame("preReset", 1'b0, 2'b01, 2'b00, 2'b00, 2'b00);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(100, 97, 1, 1, 0, 0, 0);
    @(negedge pixel_clk); #1;
    Reset = 1'b1;
    #1;
    checkFlags("asyncReset", 2'b00, 2'b00, 2'b00, 2'b00);
    checkOutput("asyncReset hit_valid", 32'(hit_valid), 32'd0);
    #1;
    Reset = 1'b0;
    pulseStart = pulseCount;
    applyStimulus(639, 479, 0, 0, 0, 0, 0);
    idle();
    idle();
    applyStimulus(639, 479, 0, 0, 0, 0, 0);
    repeat (3) idle();
    @(negedge pixel_clk); #1;
    checkOutput("postReset pulses", 32'(pulseCount - pulseStart), 32'd0);
    checkFlags("postReset", 2'b00, 2'b00, 2'b00, 2'b00);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
